// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that lets NREQ requesters share a bank
// of NFLOP JK state bits. A winning request is armed onto j/k and committed to
// q on the next rising edge of the slow clock clk, sampled on MasterClock.
//
// Ports:
//   MasterClock  sole clock
//   reset        asynchronous active-high reset
//   clk          slow design clock; a sampled 0->1 change is a commit edge
//   req          per-requester request, held until grant
//   req_op       per-requester {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   req_idx      per-requester target bit index
//   grant        one-cycle pulse when a request is committed
//   j, k         registered JK drive; only the armed bit can be non-zero
//   q            bank state
//   busy         high while ARMED or COMMIT

// One JK bit of the bank. j/k are zero for every bit except the armed one,
// so a bank-wide commit strobe only ever changes that single bit.
module jk_bank_bit (
    input  logic MasterClock,
    input  logic reset,
    input  logic commit,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge MasterClock or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (commit) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLOP = 8,
    parameter int IW    = $clog2(NFLOP)
) (
    input  logic                 MasterClock,
    input  logic                 reset,
    input  logic                 clk,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]      grant,
    output logic [NFLOP-1:0]     j,
    output logic [NFLOP-1:0]     k,
    output logic [NFLOP-1:0]     q,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic             clk_d;
    logic             clk_rise;
    logic             commit;

    logic             sel_found;
    logic [PW-1:0]    sel_id;
    logic [1:0]       sel_op;
    logic [IW-1:0]    sel_idx;
    logic [NFLOP-1:0] sel_mask;

    assign clk_rise = clk & ~clk_d;
    assign commit   = (state == ARMED) && clk_rise;

    // Round robin: the lowest requester at or above ptr wins; if none is at
    // or above ptr, the search wraps and the lowest requester overall wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_found = 1'b1;
                sel_id    = PW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) sel_id = PW'(i);
        end
    end

    always_comb begin
        sel_op  = '0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_id == PW'(i)) begin
                sel_op  = req_op[2*i +: 2];
                sel_idx = req_idx[IW*i +: IW];
            end
        end
    end

    // An out-of-range index yields an all-zero mask: the slot still runs and
    // grants, but no j/k bit is driven and q cannot change.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NFLOP; i++) sel_mask[i] = (int'(sel_idx) == i);
    end

    always_ff @(posedge MasterClock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            clk_d <= 1'b0;
            j     <= '0;
            k     <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            clk_d <= clk;
            grant <= '0;
            case (state)
                // A commit edge seen here is deliberately dropped: the command
                // is only armed this cycle and commits on a later clk edge.
                IDLE: begin
                    if (sel_found) begin
                        win   <= sel_id;
                        j     <= sel_mask & {NFLOP{sel_op[1]}};
                        k     <= sel_mask & {NFLOP{sel_op[0]}};
                        busy  <= 1'b1;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (clk_rise) begin
                        grant[win] <= 1'b1;
                        ptr        <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                        state      <= COMMIT;
                    end
                end
                // req is not looked at here, so a requester still holding req
                // in the grant-follow cycle is not re-armed twice.
                COMMIT: begin
                    j     <= '0;
                    k     <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NFLOP; g++) begin : g_bit
            jk_bank_bit u_bit (
                .MasterClock (MasterClock),
                .reset       (reset),
                .commit      (commit),
                .j           (j[g]),
                .k           (k[g]),
                .q           (q[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, NFLOP=8).
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int NFLOP = 8;
    localparam int IW    = 3;

    logic                MasterClock;
    logic                reset;
    logic                clk;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_op;
    logic [IW*NREQ-1:0]  req_idx;
    logic [NREQ-1:0]     grant;
    logic [NFLOP-1:0]    j;
    logic [NFLOP-1:0]    k;
    logic [NFLOP-1:0]    q;
    logic                busy;

    int errors = 0;
    int checks = 0;

    jk_bank_arbiter #(.NREQ(NREQ), .NFLOP(NFLOP)) dut (
        .MasterClock (MasterClock),
        .reset       (reset),
        .clk         (clk),
        .req         (req),
        .req_op      (req_op),
        .req_idx     (req_idx),
        .grant       (grant),
        .j           (j),
        .k           (k),
        .q           (q),
        .busy        (busy)
    );

    initial MasterClock = 1'b0;
    always #5 MasterClock = ~MasterClock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge MasterClock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int r, input logic [1:0] op, input logic [IW-1:0] idx);
        req_op[2*r +: 2]    = op;
        req_idx[IW*r +: IW] = idx;
    endtask

    initial begin
        logic bad;
        reset   = 1'b1;
        clk     = 1'b0;
        req     = '0;
        req_op  = '0;
        req_idx = '0;

        // reset state
        #12;
        chk("rst_q", 32'(q), 0);
        chk("rst_j", 32'(j), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // set bit 3 from requester 0, clk rises 4 cycles after the sample
        set_cmd(0, 2'b10, 3'd3);
        req = 4'b0001;
        step(1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_j", 32'(j), 32'h08);
        chk("t1_k", 32'(k), 0);
        step(3);
        chk("t1_armed_grant", 32'(grant), 0);
        chk("t1_armed_q", 32'(q), 0);
        chk("t1_armed_j", 32'(j), 32'h08);
        clk = 1'b1;
        step(1);
        chk("t1_q", 32'(q), 32'h08);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy_commit", 32'(busy), 1);
        req = '0;
        step(1);
        chk("t1_grant_off", 32'(grant), 0);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_j_off", 32'(j), 0);
        clk = 1'b0;

        // requester 2 toggles bit 3 twice, keeping req high between
        set_cmd(2, 2'b11, 3'd3);
        req = 4'b0100;
        step(1);
        chk("t2_j", 32'(j), 32'h08);
        chk("t2_k", 32'(k), 32'h08);
        clk = 1'b1;
        step(1);
        chk("t2_q1", 32'(q), 32'h00);
        chk("t2_grant1", 32'(grant), 32'h4);
        step(1);
        chk("t2_commit_busy", 32'(busy), 0);
        step(1);
        chk("t2_rearm_busy", 32'(busy), 1);
        clk = 1'b0;
        step(1);
        chk("t2_noedge_q", 32'(q), 32'h00);
        clk = 1'b1;
        step(1);
        chk("t2_q2", 32'(q), 32'h08);
        chk("t2_grant2", 32'(grant), 32'h4);
        req = '0;
        step(1);
        clk = 1'b0;

        // fairness from ptr=0: all four set their own bit, req[1] re-requests
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_cmd(i, 2'b10, IW'(i));
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            step(1);
            chk("t3_j", 32'(j), 32'(1 << i));
            clk = 1'b1;
            step(1);
            chk("t3_grant", 32'(grant), 32'(1 << i));
            chk("t3_q", 32'(q), 32'((1 << (i + 1)) - 1));
            if (i != 1) req[i] = 1'b0;
            clk = 1'b0;
            step(1);
        end
        step(1);
        chk("t3_j_again", 32'(j), 32'h02);
        clk = 1'b1;
        step(1);
        chk("t3_grant_again", 32'(grant), 32'h2);
        chk("t3_q_again", 32'(q), 32'h0F);
        req = '0;
        clk = 1'b0;
        step(1);

        // clk held low: requester 1 (toggle bit 5) stays armed
        set_cmd(1, 2'b11, 3'd5);
        req = 4'b0010;
        step(1);
        bad = 1'b0;
        for (int i = 0; i < 55; i++) begin
            step(1);
            if (busy !== 1'b1 || grant !== '0 || q !== 8'h0F) bad = 1'b1;
        end
        chk("t4_stall", 32'(bad), 0);
        clk = 1'b1;
        step(1);
        chk("t4_grant", 32'(grant), 32'h2);
        chk("t4_q", 32'(q), 32'h2F);
        req = '0;
        clk = 1'b0;
        step(1);

        // commit edge coincides with the IDLE sample: it must be ignored
        set_cmd(0, 2'b01, 3'd0);
        req = 4'b0001;
        clk = 1'b1;
        step(1);
        chk("t5_same_grant", 32'(grant), 0);
        chk("t5_same_q", 32'(q), 32'h2F);
        chk("t5_same_busy", 32'(busy), 1);
        step(2);
        chk("t5_hold_grant", 32'(grant), 0);
        clk = 1'b0;
        step(1);
        clk = 1'b1;
        step(1);
        chk("t5_grant", 32'(grant), 32'h1);
        chk("t5_q", 32'(q), 32'h2E);
        req = '0;
        clk = 1'b0;
        step(1);

        // async reset mid-ARMED; ptr is 1 before it, 0 after
        set_cmd(2, 2'b10, 3'd7);
        req = 4'b0100;
        step(1);
        chk("t6_armed_j", 32'(j), 32'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_j", 32'(j), 0);
        chk("t6_rst_k", 32'(k), 0);
        chk("t6_rst_q", 32'(q), 0);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        set_cmd(0, 2'b10, 3'd4);
        req = 4'b0101;
        #2;
        reset = 1'b0;
        step(1);
        chk("t6_restart_j", 32'(j), 32'h10);
        clk = 1'b1;
        step(1);
        chk("t6_restart_grant", 32'(grant), 32'h1);
        chk("t6_restart_q", 32'(q), 32'h10);
        req = '0;
        clk = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
